mimc_cipher_round_unit: RTL and testbench

One MiMC cipher round over the BN254 scalar field: `out = (in + key + round_constant)^7 mod MODULUS`. It is the iterative datapath stage of the MiMC hash/cipher. A sequencer feeds it a state word, key and per-round constant, then waits for `done`. It is built from a shift-and-add ("peasant") modular multiplier and a three-stage parallel power-of-7 schedule.

---
 rtl/mimc_cipher_round_unit.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_mimc_cipher_round_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mimc_cipher_round_unit.sv
// One MiMC round over the BN254 scalar field: out = (in + key + rc)^7 mod p.
// The result is built from a one-cycle double modular add, followed by three
// N_BITS-cycle phases of bit-serial ("peasant") modular multiplication.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for en; operands are captured on the start edge
// ADD   | x = ((in + key) mod p + rc) mod p, one cycle
// SQ    | mult_a: x2 = x*x
// MUL34 | mult_b: x3 = x2*x and mult_c: x4 = x2*x2, run side by side
// MUL7  | mult_a reused: x7 = x3*x4
// DONE  | first cycle publishes x7 and raises done; then held while en=1

// Bit-serial modular multiplier accumulator: each step doubles acc mod p,
// then conditionally adds a mod p. The caller supplies b one bit per step,
// MSB first, so acc = a*b mod p after N_BITS steps from a cleared start.
module mimc_peasant_mult #(
    parameter int                N_BITS  = 254,
    parameter logic [N_BITS-1:0] MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    input  logic              b_bit,
    input  logic [N_BITS-1:0] a,
    output logic [N_BITS-1:0] acc
);

    localparam logic [N_BITS:0] P_EXT = {1'b0, MODULUS};

    logic [N_BITS:0]   dbl;
    logic [N_BITS:0]   dbl_red;
    logic [N_BITS:0]   sum;
    logic [N_BITS:0]   sum_red;
    logic [N_BITS-1:0] addend;
    logic [N_BITS-1:0] acc_next;

    // One double-and-add step; each half needs only one conditional subtract
    // because both operands are already reduced below p.
    always_comb begin
        dbl      = {acc, 1'b0};
        dbl_red  = (dbl >= P_EXT) ? (dbl - P_EXT) : dbl;
        addend   = b_bit ? a : '0;
        sum      = dbl_red + {1'b0, addend};
        sum_red  = (sum >= P_EXT) ? (sum - P_EXT) : sum;
        acc_next = sum_red[N_BITS-1:0];
    end

    // Accumulator register; clear has priority over step so a phase can
    // restart the accumulator on the same edge the previous phase ends.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (step) begin
            acc <= acc_next;
        end
    end

endmodule

module mimc_cipher_round_unit #(
    parameter int                N_BITS                   = 254,
    parameter logic [N_BITS-1:0] MODULUS                  = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter string             GALOIS_MULT_METHOD       = "peasant",
    parameter string             GALOIS_POW_7_METHOD      = "parallel",
    parameter string             MIMC_CIPHER_ROUND_METHOD = "v2"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_BITS-1:0] in,
    input  logic [N_BITS-1:0] round_constant,
    input  logic [N_BITS-1:0] key,
    output logic [N_BITS-1:0] out,
    output logic              done
);

    localparam logic [N_BITS:0] P_EXT = {1'b0, MODULUS};
    localparam int              CW    = $clog2(N_BITS);
    localparam logic [CW-1:0]   CNT_TOP = CW'(N_BITS - 1);

    if (GALOIS_MULT_METHOD != "peasant") begin : g_bad_mult_method
        $error("mimc_cipher_round_unit: GALOIS_MULT_METHOD must be \"peasant\"");
    end
    if (GALOIS_POW_7_METHOD != "parallel") begin : g_bad_pow7_method
        $error("mimc_cipher_round_unit: GALOIS_POW_7_METHOD must be \"parallel\"");
    end
    if (MIMC_CIPHER_ROUND_METHOD != "v2") begin : g_bad_round_method
        $error("mimc_cipher_round_unit: MIMC_CIPHER_ROUND_METHOD must be \"v2\"");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADD   = 3'd1,
        SQ    = 3'd2,
        MUL34 = 3'd3,
        MUL7  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state, state_next;

    logic [N_BITS-1:0] in_q;
    logic [N_BITS-1:0] key_q;
    logic [N_BITS-1:0] rc_q;
    logic [N_BITS-1:0] x_q;
    logic [CW-1:0]     cnt;

    logic cnt_last;
    logic capture;
    logic do_add;
    logic cnt_load;
    logic cnt_dec;
    logic clear_a, clear_b, clear_c;
    logic step_a, step_b, step_c;
    logic publish;
    logic retire;

    logic [N_BITS-1:0] acc_a, acc_b, acc_c;
    logic [N_BITS-1:0] opa_a, opb_a;
    logic              bit_a, bit_b, bit_c;
    logic [N_BITS-1:0] x_sum;

    function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] a,
                                                  input logic [N_BITS-1:0] b);
        logic [N_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= P_EXT) begin
            s = s - P_EXT;
        end
        return s[N_BITS-1:0];
    endfunction

    assign cnt_last = (cnt == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-phase datapath strobes.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        do_add     = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        clear_a    = 1'b0;
        clear_b    = 1'b0;
        clear_c    = 1'b0;
        step_a     = 1'b0;
        step_b     = 1'b0;
        step_c     = 1'b0;
        publish    = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    capture    = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                do_add     = 1'b1;
                clear_a    = 1'b1;
                cnt_load   = 1'b1;
                state_next = SQ;
            end
            SQ: begin
                step_a = 1'b1;
                if (cnt_last) begin
                    clear_b    = 1'b1;
                    clear_c    = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = MUL34;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            MUL34: begin
                step_b = 1'b1;
                step_c = 1'b1;
                if (cnt_last) begin
                    // x2 in acc_a is consumed on this same edge, so mult_a
                    // can be cleared for the final product.
                    clear_a    = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = MUL7;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            MUL7: begin
                step_a = 1'b1;
                if (cnt_last) begin
                    state_next = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                // The first DONE cycle always publishes, so done pulses for
                // at least one cycle even when en was dropped long ago.
                if (!done) begin
                    publish = 1'b1;
                end else if (!en) begin
                    retire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand routing: mult_a squares x in SQ and forms x3*x4 in MUL7;
    // mult_b and mult_c both take x2 from acc_a during MUL34.
    always_comb begin
        opa_a = x_q;
        opb_a = x_q;
        if (state == MUL7) begin
            opa_a = acc_b;
            opb_a = acc_c;
        end
        bit_a = opb_a[cnt];
        bit_b = x_q[cnt];
        bit_c = acc_a[cnt];
    end

    assign x_sum = mod_add(mod_add(in_q, key_q), rc_q);

    // Operand capture, pre-exponentiation add, and the bit-index down-counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_q  <= '0;
            key_q <= '0;
            rc_q  <= '0;
            x_q   <= '0;
            cnt   <= '0;
        end else begin
            if (capture) begin
                in_q  <= in;
                key_q <= key;
                rc_q  <= round_constant;
            end
            if (do_add) begin
                x_q <= x_sum;
            end
            if (cnt_load) begin
                cnt <= CNT_TOP;
            end else if (cnt_dec) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Result register and done flag; out keeps its value after retiring.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out  <= '0;
            done <= 1'b0;
        end else if (publish) begin
            out  <= acc_a;
            done <= 1'b1;
        end else if (retire) begin
            done <= 1'b0;
        end
    end

    mimc_peasant_mult #(
        .N_BITS  (N_BITS),
        .MODULUS (MODULUS)
    ) u_mult_a (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_a),
        .step  (step_a),
        .b_bit (bit_a),
        .a     (opa_a),
        .acc   (acc_a)
    );

    mimc_peasant_mult #(
        .N_BITS  (N_BITS),
        .MODULUS (MODULUS)
    ) u_mult_b (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_b),
        .step  (step_b),
        .b_bit (bit_b),
        .a     (acc_a),
        .acc   (acc_b)
    );

    mimc_peasant_mult #(
        .N_BITS  (N_BITS),
        .MODULUS (MODULUS)
    ) u_mult_c (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_c),
        .step  (step_c),
        .b_bit (bit_c),
        .a     (acc_a),
        .acc   (acc_c)
    );

endmodule

// File: tb/tb_mimc_cipher_round_unit.sv
// Scoreboard bench for mimc_cipher_round_unit: expected round results are
// queued at start and compared when done rises.
module tb_mimc_cipher_round_unit;

    localparam int           NB    = 254;
    localparam logic [253:0] P     = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam int           LAT   = 3 * NB + 2;
    localparam int           NEVER = 100000;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en  = 1'b0;
    logic [253:0]   din = '0;
    logic [253:0]   rc  = '0;
    logic [253:0]   key = '0;
    logic [253:0]   dout;
    logic           done;

    int n_checks = 0;
    int n_errors = 0;

    logic [253:0] exp_q[$];

    mimc_cipher_round_unit dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .in             (din),
        .round_constant (rc),
        .key            (key),
        .out            (dout),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [253:0] mulmod(input logic [253:0] x, input logic [253:0] y);
        logic [511:0] t;
        t = {258'd0, x} * {258'd0, y};
        t = t % {258'd0, P};
        return t[253:0];
    endfunction

    function automatic logic [253:0] model(input logic [253:0] a, input logic [253:0] b,
                                           input logic [253:0] c);
        logic [255:0] s;
        logic [253:0] s1, s2, s3, s4;
        s  = {2'b0, a} + {2'b0, b} + {2'b0, c};
        s  = s % {2'b0, P};
        s1 = s[253:0];
        s2 = mulmod(s1, s1);
        s3 = mulmod(s2, s1);
        s4 = mulmod(s2, s2);
        return mulmod(s3, s4);
    endfunction

    function automatic logic [253:0] rnd_fe();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        r = r % {2'b0, P};
        return r[253:0];
    endfunction

    // Start a round, scramble inputs after capture, then wait for done and
    // score latency, result and the done/out handshake behaviour.
    task automatic run_round(input logic [253:0] a, input logic [253:0] b, input logic [253:0] c,
                             input logic [253:0] exp, input int drop_at);
        int           cyc;
        logic         seen;
        logic [253:0] e;
        din = a;
        key = b;
        rc  = c;
        en  = 1'b1;
        exp_q.push_back(exp);
        tick();
        din = rnd_fe();
        key = rnd_fe();
        rc  = rnd_fe();
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 2 * LAT && !seen) begin
            if (cyc == drop_at) en = 1'b0;
            tick();
            cyc++;
            if (done) seen = 1'b1;
        end
        e = exp_q.pop_front();
        if (!seen) begin
            check_val("done_timeout", 0, 1);
            en  = 1'b0;
            rst = 1'b0;
            tick();
            rst = 1'b1;
            tick();
            return;
        end
        check_val("latency", cyc, LAT);
        check_val("result", dout, e);
        if (en) begin
            tick();
            check_val("done_hold", done, 1);
            check_val("out_hold", dout, e);
            en = 1'b0;
        end
        tick();
        check_val("done_drop", done, 0);
        check_val("out_keep", dout, e);
        tick();
        check_val("idle_done", done, 0);
    endtask

    initial begin
        logic [253:0] a, b, c;
        int           drop;

        // Reset held with en high: nothing may start.
        rst = 1'b0;
        en  = 1'b1;
        din = 254'd5;
        tick();
        tick();
        check_val("reset_done", done, 0);
        check_val("reset_out", dout, 0);
        en  = 1'b0;
        rst = 1'b1;
        tick();
        check_val("post_reset_done", done, 0);
        check_val("post_reset_out", dout, 0);

        run_round(254'd2, 254'd0, 254'd0, 254'h80, NEVER);
        run_round(254'd0, 254'd0, 254'd3, 254'h88b, NEVER);
        run_round(254'd1, 254'd0, 254'd3, 254'h4000, 200);
        run_round(P - 254'd1, 254'd0, 254'd0, P - 254'd1, NEVER);
        run_round(P - 254'd1, 254'd1, 254'd0, 254'd0, 0);
        run_round(P - 254'd1, P - 254'd1, 254'd2, 254'd0, NEVER);

        // Reset in the middle of MUL34 discards the round.
        din = rnd_fe();
        key = rnd_fe();
        rc  = rnd_fe();
        en  = 1'b1;
        tick();
        repeat (NB + 1 + 100) tick();
        rst = 1'b0;
        tick();
        check_val("abort_done", done, 0);
        check_val("abort_out", dout, 0);
        rst = 1'b1;
        en  = 1'b0;
        tick();
        check_val("abort_idle_done", done, 0);
        a = rnd_fe();
        b = rnd_fe();
        c = rnd_fe();
        run_round(a, b, c, model(a, b, c), NEVER);

        for (int i = 0; i < 20; i++) begin
            a = rnd_fe();
            b = rnd_fe();
            c = rnd_fe();
            if (i % 5 == 0) a = P - 254'd1 - 254'(i);
            if (i % 3 == 0)      drop = 0;
            else if (i % 3 == 1) drop = 300 + 10 * i;
            else                 drop = NEVER;
            run_round(a, b, c, model(a, b, c), drop);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
